top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 45 ++++
 rtl/arm_core.sv | 73 +++++++
 rtl/top.sv | 51 +++++
 tb/tb_top.sv | 108 ++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// top_pkg: shared enums, condition evaluation and ROM image for the ARM-subset core
package top_pkg;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR} alu_ctrl_t;

  typedef enum logic [3:0] {
    COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
    COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
  } cond_t;

  typedef enum logic [1:0] {OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10} op_t;

  typedef enum logic [3:0] {
    CMD_AND = 4'h0, CMD_SUB = 4'h2, CMD_ADD = 4'h4, CMD_ORR = 4'hc
  } cmd_t;

  localparam logic [0:7][31:0] ROM_IMAGE = {
    32'hE04F000F, 32'hE2801018, 32'hE2802064, 32'hE2514018,
    32'h15820000, 32'h05821000, 32'hE5923000, 32'hEAFFFFFE
  };

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond_t'(cond))
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = !z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = !c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = !n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = !v;
      COND_HI: cond_pass = c && !z;
      COND_LS: cond_pass = !c || z;
      COND_GE: cond_pass = n == v;
      COND_LT: cond_pass = n != v;
      COND_GT: cond_pass = !z && (n == v);
      COND_LE: cond_pass = z || (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_core.sv
// arm_core: single-cycle controller and datapath for the ADD/SUB/AND/ORR/LDR/STR/B subset
module arm_core
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] read_data,
  output logic [29:0] iaddr,
  output logic        mem_write,
  output logic [31:0] alu_result,
  output logic [31:0] write_data
);

  logic [31:0] pc, pc8, rd1, rd2, srca, srcb, bb, result;
  logic [31:0] rf [15];
  logic [32:0] sum;
  logic [3:0]  flags, alu_flags, ra2;
  logic        is_dp, is_mem, is_ldr, is_br, pass, wr, rd_pc, sub, arith;
  alu_ctrl_t   alu_ctrl;

  assign pc8    = pc + 32'd8;
  assign iaddr  = pc[31:2];
  assign is_dp  = instr[27:26] == OP_DP && (instr[24:21] == CMD_ADD || instr[24:21] == CMD_SUB ||
                  instr[24:21] == CMD_AND || instr[24:21] == CMD_ORR);
  assign is_mem = instr[27:26] == OP_MEM && instr[25:21] == 5'b01100;
  assign is_ldr = is_mem && instr[20];
  assign is_br  = instr[27:24] == {OP_BR, 2'b10};
  assign pass   = cond_pass(instr[31:28], flags);
  assign wr     = pass && (is_dp || is_ldr);
  assign rd_pc  = instr[15:12] == 4'hf;

  // operand fetch, ALU and flag generation
  always_comb begin
    ra2        = is_mem ? instr[15:12] : instr[3:0];
    rd1        = instr[19:16] == 4'hf ? pc8 : rf[instr[19:16]];
    rd2        = ra2 == 4'hf ? pc8 : rf[ra2];
    alu_ctrl   = (is_br || is_mem) ? ALU_ADD :
                 instr[24:21] == CMD_SUB ? ALU_SUB :
                 instr[24:21] == CMD_AND ? ALU_AND :
                 instr[24:21] == CMD_ORR ? ALU_ORR : ALU_ADD;
    srca       = is_br ? pc8 : rd1;
    srcb       = is_br ? {{6{instr[23]}}, instr[23:0], 2'b00} :
                 is_mem ? {20'd0, instr[11:0]} :
                 instr[25] ? {24'd0, instr[7:0]} : rd2;
    sub        = alu_ctrl == ALU_SUB;
    arith      = alu_ctrl == ALU_ADD || sub;
    bb         = sub ? ~srcb : srcb;
    sum        = {1'b0, srca} + {1'b0, bb} + {32'd0, sub};
    alu_result = alu_ctrl == ALU_AND ? srca & srcb :
                 alu_ctrl == ALU_ORR ? srca | srcb : sum[31:0];
    alu_flags  = {alu_result[31], alu_result == 32'd0, arith && sum[32],
                  arith && (srca[31] == bb[31]) && (alu_result[31] != srca[31])};
    result     = is_ldr ? read_data : alu_result;
    mem_write  = pass && is_mem && !instr[20];
    write_data = rd2;
  end

  // PC and NZCV, cleared asynchronously by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= '0;
      flags <= '0;
    end else begin
      pc <= (pass && is_br) ? alu_result : (wr && rd_pc) ? result : pc + 32'd4;
      if (pass && is_dp && instr[20]) flags <= alu_flags;
    end
  end

  // register file write port; R15 is the PC and never lands here
  always_ff @(posedge clk) if (wr && !rd_pc) rf[instr[15:12]] <= result;

endmodule

// File: rtl/top.sv
// top: ARM-subset processor with instruction ROM and data RAM around arm_core
module top
  import top_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemWrite,
  output logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] ALUResult
);

  localparam int IW = IMEM_WORDS > 1 ? $clog2(IMEM_WORDS) : 1;
  localparam int DW = DMEM_WORDS > 1 ? $clog2(DMEM_WORDS) : 1;

  logic [31:0]   imem [IMEM_WORDS];
  logic [31:0]   dmem [DMEM_WORDS];
  logic [31:0]   instr;
  logic [29:0]   iaddr;
  logic [DW-1:0] daddr;

  for (genvar g = 0; g < IMEM_WORDS; g++) begin : g_rom
    if (g < 8) begin : g_img
      assign imem[g] = ROM_IMAGE[g];
    end else begin : g_zero
      assign imem[g] = '0;
    end
  end

  assign instr    = iaddr < 30'(IMEM_WORDS) ? imem[iaddr[IW-1:0]] : '0;
  assign daddr    = DW'(ALUResult[31:2] % 30'(DMEM_WORDS));
  assign ReadData = dmem[daddr];

  // data RAM write port
  always_ff @(posedge clk) if (MemWrite) dmem[daddr] <= WriteData;

  arm_core u_core (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .read_data  (ReadData),
    .iaddr      (iaddr),
    .mem_write  (MemWrite),
    .alu_result (ALUResult),
    .write_data (WriteData)
  );

endmodule

// File: tb/tb_top.sv
// tb_top: scoreboard bench running the built-in program, with two reset restarts
module tb_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] WriteData, ReadData, ALUResult;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic        mw;
    bit          ca;
    logic [31:0] alu;
    bit          cw;
    logic [31:0] wd;
    bit          cr;
    logic [31:0] rdd;
  } exp_t;

  exp_t sb[$];

  top dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .ALUResult (ALUResult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t exp_for(input int c, input bit second);
    exp_t e = '{pc: 32'h1c, mw: 1'b0, ca: 1'b0, alu: '0, cw: 1'b0, wd: '0, cr: 1'b0, rdd: '0};
    if (c <= 7) e.pc = 32'((c - 1) * 4);
    case (c)
      1: begin e.ca = 1; e.alu = 0; end
      2: begin e.ca = 1; e.alu = 24; end
      3: begin e.ca = 1; e.alu = 100; end
      4: begin e.ca = 1; e.alu = 0; end
      5: begin e.ca = 1; e.alu = 100; e.cr = second; e.rdd = 24; end
      6: begin e.mw = 1; e.ca = 1; e.alu = 100; e.cw = 1; e.wd = 24; e.cr = second; e.rdd = 24; end
      7: begin e.ca = 1; e.alu = 100; e.cr = 1; e.rdd = 24; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run(input bit second, input int n);
    exp_t e;
    for (int c = 1; c <= n; c++) sb.push_back(exp_for(c, second));
    for (int c = 1; c <= n; c++) begin
      e = sb.pop_front();
      chk($sformatf("r%0d_c%0d_pc", second, c), dut.u_core.pc, e.pc);
      chk($sformatf("r%0d_c%0d_mw", second, c), MemWrite, e.mw);
      if (e.ca) chk($sformatf("r%0d_c%0d_alu", second, c), ALUResult, e.alu);
      if (e.cw) chk($sformatf("r%0d_c%0d_wd", second, c), WriteData, e.wd);
      if (e.cr) chk($sformatf("r%0d_c%0d_rd", second, c), ReadData, e.rdd);
      if (c == 5) chk($sformatf("r%0d_nzcv", second), dut.u_core.flags, 32'b0110);
      if (c == 8) chk($sformatf("r%0d_r3", second), dut.u_core.rf[3], 32'd24);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", dut.u_core.pc, 32'h0);
    chk("rst_mw", MemWrite, 32'h0);
    chk("rst_nzcv", dut.u_core.flags, 32'h0);
    #1 reset = 1'b0;
    #1;
    run(1'b0, 28);
    reset = 1'b1;
    #1;
    chk("mid_pc", dut.u_core.pc, 32'h0);
    chk("mid_nzcv", dut.u_core.flags, 32'h0);
    chk("mid_mw", MemWrite, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_hold_pc", dut.u_core.pc, 32'h0);
    reset = 1'b0;
    #1;
    run(1'b1, 2);
    reset = 1'b1;
    #1;
    chk("c3_rst_pc", dut.u_core.pc, 32'h0);
    chk("c3_rst_mw", MemWrite, 32'h0);
    #1 reset = 1'b0;
    #1;
    run(1'b1, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
